// File: rtl/store_unit.sv
// rtl/store_unit.sv - aligned data-memory store path with pipeline stall
// Optional WRITE-state timeout abort is built when STORE_TIMEOUT_EN is defined.
module store_unit
`ifdef STORE_TIMEOUT_EN
  #(parameter int TIMEOUT = 16)
`endif
(
  input  logic        clock,
  input  logic        reset,
  input  logic        storeReq,
  input  logic [1:0]  storeSize,
  input  logic [31:0] storeAddr,
  input  logic [31:0] storeData,
  output logic        stall,
  output logic        storeDone,
  output logic        storeError,
  output logic        memWrite,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic [3:0]  memByteEn,
  input  logic        memReady
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE, ERR} state_t;

  state_t      state_q, state_d;
  logic        accept;
  logic        illegal;
  logic [31:0] wdata_new;
  logic [3:0]  be_new;

  logic        stall_q, done_q, error_q, mem_write_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;

`ifdef STORE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    illegal   = (storeSize == 2'b11) ||
                (storeSize == 2'b01 && storeAddr[0]) ||
                (storeSize == 2'b00 && storeAddr[1:0] != 2'b00);
    wdata_new = storeData;
    be_new    = 4'b1111;
    case (storeSize)
      2'b10: begin
        wdata_new = {4{storeData[7:0]}};
        be_new    = 4'b0001 << storeAddr[1:0];
      end
      2'b01: begin
        wdata_new = {2{storeData[15:0]}};
        be_new    = storeAddr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_new = storeData;
        be_new    = 4'b1111;
      end
    endcase
  end

  // DONE and ERR already behave as IDLE so a new request is taken in the pulse cycle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
`ifdef STORE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      WRITE: begin
        if (memReady) begin
          state_d = DONE;
        end
`ifdef STORE_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(TIMEOUT)) state_d = ERR;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        if (storeReq) begin
          if (illegal) begin
            state_d = ERR;
          end else begin
            state_d = WRITE;
            accept  = 1'b1;
`ifdef STORE_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      stall_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
`ifdef STORE_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      stall_q     <= (state_d == WRITE);
      mem_write_q <= (state_d == WRITE);
      done_q      <= (state_d == DONE);
      error_q     <= (state_d == ERR);
      if (accept) begin
        mem_addr_q  <= {storeAddr[31:2], 2'b00};
        mem_wdata_q <= wdata_new;
        mem_be_q    <= be_new;
      end else if (state_d != WRITE) begin
        mem_be_q    <= '0;
      end
`ifdef STORE_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign stall      = stall_q;
  assign storeDone  = done_q;
  assign storeError = error_q;
  assign memWrite   = mem_write_q;
  assign memAddr    = mem_addr_q;
  assign memWData   = mem_wdata_q;
  assign memByteEn  = mem_be_q;

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - scoreboard bench for store_unit
module tb_store_unit;

  logic        clock = 1'b0;
  logic        reset, storeReq, memReady;
  logic [1:0]  storeSize;
  logic [31:0] storeAddr, storeData;
  logic        stall, storeDone, storeError, memWrite;
  logic [31:0] memAddr, memWData;
  logic [3:0]  memByteEn;

  store_unit dut (
    .clock(clock), .reset(reset), .storeReq(storeReq), .storeSize(storeSize),
    .storeAddr(storeAddr), .storeData(storeData), .stall(stall),
    .storeDone(storeDone), .storeError(storeError), .memWrite(memWrite),
    .memAddr(memAddr), .memWData(memWData), .memByteEn(memByteEn),
    .memReady(memReady)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  localparam int K_W = 0, K_DONE = 1, K_ERR = 2;
  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          len;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be, input int len);
    exp_t e;
    e.kind = kind; e.cyc = c; e.addr = a; e.data = d; e.be = be; e.len = len;
    sbq.push_back(e);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                          input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] ebe,
                          input int dly);
    push(K_W, cyc + 1 + dly, ea, ed, ebe, dly + 1);
    push(K_DONE, cyc + 2 + dly, 32'h0, 32'h0, 4'h0, 0);
    storeReq = 1'b1; storeAddr = a; storeData = d; storeSize = sz;
    memReady = (dly == 0);
    @(posedge clock); #1;
    storeReq = 1'b0;
    repeat (dly) begin @(posedge clock); #1; end
    memReady = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic do_bad(input logic [31:0] a, input logic [1:0] sz);
    push(K_ERR, cyc + 1, 32'h0, 32'h0, 4'h0, 0);
    storeReq = 1'b1; storeAddr = a; storeData = 32'hFFFF_FFFF; storeSize = sz;
    memReady = 1'b1;
    @(posedge clock); #1;
    storeReq = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_memWrite"},   32'(memWrite),   32'h0);
    chk({tag, "_stall"},      32'(stall),      32'h0);
    chk({tag, "_storeDone"},  32'(storeDone),  32'h0);
    chk({tag, "_storeError"}, 32'(storeError), 32'h0);
    chk({tag, "_memAddr"},    memAddr,         32'h0);
    chk({tag, "_memWData"},   memWData,        32'h0);
    chk({tag, "_memByteEn"},  32'(memByteEn),  32'h0);
  endtask

  int          run = 0;
  int          last_run = 0;
  logic [31:0] a0, d0;
  logic [3:0]  b0;

  always @(negedge clock) begin
    exp_t e;
    if (memWrite === 1'b1) begin
      run++;
      chk("stall_in_write", 32'(stall), 32'h1);
      if (run == 1) begin
        a0 = memAddr; d0 = memWData; b0 = memByteEn;
      end else begin
        chk("hold_addr", memAddr, a0);
        chk("hold_data", memWData, d0);
        chk("hold_be", 32'(memByteEn), 32'(b0));
      end
      if (memReady) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got addr %h want no write", memAddr);
        end else begin
          e = sbq.pop_front();
          chk("write_kind", e.kind, K_W);
          chk("write_cyc", cyc, e.cyc);
          chk("write_addr", memAddr, e.addr);
          chk("write_data", memWData, e.data);
          chk("write_be", 32'(memByteEn), 32'(e.be));
          chk("write_len", run, e.len);
        end
        run = 0;
      end
    end else begin
      if (run != 0) last_run = run;
      run = 0;
    end
    if (storeDone === 1'b1) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got pulse at cycle %0d want none", cyc);
      end else begin
        e = sbq.pop_front();
        chk("done_kind", e.kind, K_DONE);
        chk("done_cyc", cyc, e.cyc);
        chk("done_be", 32'(memByteEn), 32'h0);
        chk("done_memWrite", 32'(memWrite), 32'h0);
        chk("done_stall", 32'(stall), 32'h0);
      end
    end
    if (storeError === 1'b1) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_error: got pulse at cycle %0d want none", cyc);
      end else begin
        e = sbq.pop_front();
        chk("err_kind", e.kind, K_ERR);
        chk("err_cyc", cyc, e.cyc);
        chk("err_write_cycles", last_run, e.len);
        chk("err_memWrite", 32'(memWrite), 32'h0);
        chk("err_stall", 32'(stall), 32'h0);
      end
      last_run = 0;
    end
    if (reset === 1'b1) begin
      run = 0;
      last_run = 0;
    end
  end

  initial begin
    reset = 1'b1; storeReq = 1'b0; storeSize = 2'b00;
    storeAddr = 32'h0; storeData = 32'h0; memReady = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    do_store(32'h0000_0100, 32'hDEAD_BEEF, 2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 0);
    do_store(32'h0000_0203, 32'h0000_00A5, 2'b10, 32'h0000_0200, 32'hA5A5_A5A5, 4'b1000, 0);
    do_store(32'h0000_0202, 32'h0000_1234, 2'b01, 32'h0000_0200, 32'h1234_1234, 4'b1100, 0);
    do_store(32'h0000_0001, 32'hFFFF_FF77, 2'b10, 32'h0000_0000, 32'h7777_7777, 4'b0010, 0);
    do_store(32'h0000_0000, 32'hABCD_5678, 2'b01, 32'h0000_0000, 32'h5678_5678, 4'b0011, 0);
    do_store(32'h0000_0400, 32'h0123_4567, 2'b00, 32'h0000_0400, 32'h0123_4567, 4'b1111, 5);

    do_bad(32'h0000_0102, 2'b00);
    do_bad(32'h0000_0101, 2'b01);
    do_bad(32'h0000_0000, 2'b11);
    @(posedge clock); #1;

`ifdef STORE_TIMEOUT_EN
    push(K_ERR, cyc + 17, 32'h0, 32'h0, 4'h0, 16);
    storeReq = 1'b1; storeAddr = 32'h0000_0500; storeData = 32'h5555_AAAA;
    storeSize = 2'b00; memReady = 1'b0;
    @(posedge clock); #1;
    storeReq = 1'b0;
    repeat (16) begin @(posedge clock); #1; end
    memReady = 1'b1;
    @(posedge clock); #1;
    chk("post_timeout_memWrite", 32'(memWrite), 32'h0);
`else
    do_store(32'h0000_0500, 32'h5555_AAAA, 2'b00, 32'h0000_0500, 32'h5555_AAAA, 4'b1111, 20);
`endif
    do_store(32'h0000_0600, 32'hCAFE_F00D, 2'b00, 32'h0000_0600, 32'hCAFE_F00D, 4'b1111, 15);

    storeReq = 1'b1; storeAddr = 32'h0000_0700; storeData = 32'h1111_2222;
    storeSize = 2'b00; memReady = 1'b0;
    @(posedge clock); #1;
    storeReq = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk_all_zero("wreset");
    reset = 1'b0; memReady = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    do_store(32'h0000_0802, 32'h0000_BEEF, 2'b01, 32'h0000_0800, 32'hBEEF_BEEF, 4'b1100, 1);

    repeat (5) begin @(posedge clock); #1; end
    chk("scoreboard_empty", sbq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
